// File: rtl/c7bexu_pkg.sv
// Purpose: shared constants and bypass-source encoding for the EX bypass/scoreboard block.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package c7bexu_pkg;

    localparam int REG_AW   = 5;   // architectural register index width
    localparam int NREG     = 32;  // number of architectural registers
    localparam int XLEN_DEF = 32;  // default datapath width

    // Where a read port's operand comes from, highest priority first.
    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_FWD,
        SRC_LL,
        SRC_HIST,
        SRC_RF
    } byp_src_e;

endpackage

// File: rtl/c7bexu_byp_port.sv
// Purpose: single read-port operand select (zero / forward / long-latency / history / RF) and its stall term.
// Latency: fully combinational, 0 cycles from rs_i to data_o.
// Backpressure: stall_o requests an EX hold when the selected source is not ready or the register is still pending.
//
// Ports: rs_i/used_i/rf_data_i      - port source index, use flag, register-file data
//        fwd_*_i                     - NFWD forwarding stages, index 0 youngest
//        ll_cmpl_*_i                 - long-latency result return
//        hist_*_i                    - history entries (only with C7BEXU_BYP_SB_HIST_EN), index 0 youngest
//        pend_i                      - scoreboard pending bit for rs_i
//        data_o/stall_o              - bypassed operand and this port's stall contribution
module c7bexu_byp_port
    import c7bexu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NFWD  = 2
`ifdef C7BEXU_BYP_SB_HIST_EN
  , parameter int NHIST = 1
`endif
) (
    input  logic [REG_AW-1:0]      rs_i,
    input  logic                   used_i,
    input  logic [XLEN-1:0]        rf_data_i,
    input  logic [NFWD*REG_AW-1:0] fwd_rd_i,
    input  logic [NFWD-1:0]        fwd_wen_i,
    input  logic [NFWD-1:0]        fwd_rdy_i,
    input  logic [NFWD*XLEN-1:0]   fwd_data_i,
    input  logic                   ll_cmpl_vld_i,
    input  logic [REG_AW-1:0]      ll_cmpl_rd_i,
    input  logic [XLEN-1:0]        ll_cmpl_data_i,
`ifdef C7BEXU_BYP_SB_HIST_EN
    input  logic [NHIST-1:0]        hist_vld_i,
    input  logic [NHIST*REG_AW-1:0] hist_rd_i,
    input  logic [NHIST*XLEN-1:0]   hist_data_i,
`endif
    input  logic                   pend_i,
    output logic [XLEN-1:0]        data_o,
    output logic                   stall_o
);

    byp_src_e        src;
    logic            fwd_hit;
    logic            fwd_rdy_sel;
    logic [XLEN-1:0] fwd_dat;
    logic            ll_hit;
`ifdef C7BEXU_BYP_SB_HIST_EN
    logic            hist_hit;
    logic [XLEN-1:0] hist_dat;
`endif

    always_comb begin
        fwd_hit     = 1'b0;
        fwd_rdy_sel = 1'b0;
        fwd_dat     = '0;
        // Walk oldest to youngest so the youngest matching stage wins.
        for (int i = NFWD - 1; i >= 0; i--) begin
            if (fwd_wen_i[i] && (fwd_rd_i[i*REG_AW +: REG_AW] == rs_i)) begin
                fwd_hit     = 1'b1;
                fwd_rdy_sel = fwd_rdy_i[i];
                fwd_dat     = fwd_data_i[i*XLEN +: XLEN];
            end
        end

        ll_hit = ll_cmpl_vld_i && (ll_cmpl_rd_i == rs_i);

`ifdef C7BEXU_BYP_SB_HIST_EN
        hist_hit = 1'b0;
        hist_dat = '0;
        for (int k = NHIST - 1; k >= 0; k--) begin
            if (hist_vld_i[k] && (hist_rd_i[k*REG_AW +: REG_AW] == rs_i)) begin
                hist_hit = 1'b1;
                hist_dat = hist_data_i[k*XLEN +: XLEN];
            end
        end
`endif

        if (rs_i == '0)       src = SRC_ZERO;
        else if (fwd_hit)     src = SRC_FWD;
        else if (ll_hit)      src = SRC_LL;
`ifdef C7BEXU_BYP_SB_HIST_EN
        else if (hist_hit)    src = SRC_HIST;
`endif
        else                  src = SRC_RF;

        case (src)
            SRC_ZERO: data_o = '0;
            SRC_FWD:  data_o = fwd_dat;
            SRC_LL:   data_o = ll_cmpl_data_i;
`ifdef C7BEXU_BYP_SB_HIST_EN
            SRC_HIST: data_o = hist_dat;
`endif
            default:  data_o = rf_data_i;
        endcase

        // x0 never stalls: its source is the constant, not a forward stage,
        // and the scoreboard never marks it pending.
        stall_o = used_i && (((src == SRC_FWD) && !fwd_rdy_sel) ||
                             ((rs_i != '0) && pend_i && !fwd_hit && !ll_hit));
    end

endmodule

// File: rtl/c7bexu_byp_sb.sv
// Purpose: EX operand bypass network with long-latency scoreboard and optional post-writeback history.
// Latency: bypass data and stall_e are combinational (0 cycles); scoreboard/history/sb_err update at the clock edge.
// Backpressure: stall_e holds EX on unready forwards, pending RAW sources and WAW re-issue to a pending rd.
//
// Ports: clk/resetn                          - clock, async active-low reset
//        rs_e/rs_used_e/rs_data_e            - NRP read ports: index, use flag, RF data
//        fwd_rd/fwd_wen/fwd_rdy/fwd_data     - NFWD forwarding stages (0 = youngest M, NFWD-1 = oldest W)
//        ll_issue_vld/ll_issue_rd            - long-latency issue from EX (sets pending)
//        ll_cmpl_vld/ll_cmpl_rd/ll_cmpl_data - long-latency completion (clears pending)
//        rf_wen/rf_rd/rf_wdata               - RF write port, feeds the history shift register
//        rs_data_byp_e/stall_e/sb_err        - bypassed operands, EX stall, sticky stray-completion flag
// Build option: C7BEXU_BYP_SB_HIST_EN enables the NHIST-deep history; otherwise history is absent.
module c7bexu_byp_sb
    import c7bexu_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NRP   = 2,
    parameter int NFWD  = 2,
    parameter int NHIST = 1
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NRP*REG_AW-1:0]  rs_e,
    input  logic [NRP-1:0]         rs_used_e,
    input  logic [NRP*XLEN-1:0]    rs_data_e,
    input  logic [NFWD*REG_AW-1:0] fwd_rd,
    input  logic [NFWD-1:0]        fwd_wen,
    input  logic [NFWD-1:0]        fwd_rdy,
    input  logic [NFWD*XLEN-1:0]   fwd_data,
    input  logic                   ll_issue_vld,
    input  logic [REG_AW-1:0]      ll_issue_rd,
    input  logic                   ll_cmpl_vld,
    input  logic [REG_AW-1:0]      ll_cmpl_rd,
    input  logic [XLEN-1:0]        ll_cmpl_data,
    input  logic                   rf_wen,
    input  logic [REG_AW-1:0]      rf_rd,
    input  logic [XLEN-1:0]        rf_wdata,
    output logic [NRP*XLEN-1:0]    rs_data_byp_e,
    output logic                   stall_e,
    output logic                   sb_err
);

    logic [NREG-1:0] pend_q, pend_d;
    logic            sb_err_q, sb_err_d;
    logic [NRP-1:0]  port_stall;
    logic            waw_stall;

`ifdef C7BEXU_BYP_SB_HIST_EN
    logic [NHIST-1:0]        hist_vld_q;
    logic [NHIST*REG_AW-1:0] hist_rd_q;
    logic [NHIST*XLEN-1:0]   hist_data_q;

    // Entry 0 is the most recent RF write; the oldest entry falls off the end.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hist_vld_q  <= '0;
            hist_rd_q   <= '0;
            hist_data_q <= '0;
        end else begin
            for (int k = NHIST - 1; k > 0; k--) begin
                hist_vld_q[k]                   <= hist_vld_q[k-1];
                hist_rd_q[k*REG_AW +: REG_AW]   <= hist_rd_q[(k-1)*REG_AW +: REG_AW];
                hist_data_q[k*XLEN +: XLEN]     <= hist_data_q[(k-1)*XLEN +: XLEN];
            end
            hist_vld_q[0]             <= rf_wen && (rf_rd != '0);
            hist_rd_q[0 +: REG_AW]    <= rf_rd;
            hist_data_q[0 +: XLEN]    <= rf_wdata;
        end
    end
`else
    logic unused_hist;
    assign unused_hist = ^{rf_wen, rf_rd, rf_wdata, (NHIST != 0)};
`endif

    for (genvar p = 0; p < NRP; p++) begin : g_port
        c7bexu_byp_port #(
            .XLEN  (XLEN),
            .NFWD  (NFWD)
`ifdef C7BEXU_BYP_SB_HIST_EN
          , .NHIST (NHIST)
`endif
        ) u_port (
            .rs_i           (rs_e[p*REG_AW +: REG_AW]),
            .used_i         (rs_used_e[p]),
            .rf_data_i      (rs_data_e[p*XLEN +: XLEN]),
            .fwd_rd_i       (fwd_rd),
            .fwd_wen_i      (fwd_wen),
            .fwd_rdy_i      (fwd_rdy),
            .fwd_data_i     (fwd_data),
            .ll_cmpl_vld_i  (ll_cmpl_vld),
            .ll_cmpl_rd_i   (ll_cmpl_rd),
            .ll_cmpl_data_i (ll_cmpl_data),
`ifdef C7BEXU_BYP_SB_HIST_EN
            .hist_vld_i     (hist_vld_q),
            .hist_rd_i      (hist_rd_q),
            .hist_data_i    (hist_data_q),
`endif
            .pend_i         (pend_q[rs_e[p*REG_AW +: REG_AW]]),
            .data_o         (rs_data_byp_e[p*XLEN +: XLEN]),
            .stall_o        (port_stall[p])
        );
    end

    // Re-issuing to a still-pending rd would lose track of the first result,
    // unless that result is landing this very cycle.
    assign waw_stall = ll_issue_vld && (ll_issue_rd != '0) && pend_q[ll_issue_rd] &&
                       !(ll_cmpl_vld && (ll_cmpl_rd == ll_issue_rd));

    assign stall_e = (|port_stall) || waw_stall;

    // Clear before set so a same-rd completion and new issue leaves it pending.
    always_comb begin
        pend_d   = pend_q;
        sb_err_d = sb_err_q;
        if (ll_cmpl_vld) begin
            if (pend_q[ll_cmpl_rd]) pend_d[ll_cmpl_rd] = 1'b0;
            else                    sb_err_d           = 1'b1;
        end
        if (ll_issue_vld && !stall_e && (ll_issue_rd != '0)) begin
            pend_d[ll_issue_rd] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            sb_err_q <= sb_err_d;
        end
    end

    assign sb_err = sb_err_q;

endmodule

// File: tb/tb_c7bexu_byp_sb.sv
module tb_c7bexu_byp_sb;

    localparam int XLEN  = 32;
    localparam int NRP   = 2;
    localparam int NFWD  = 2;
    localparam int NHIST = 1;

    logic                 clk = 1'b0;
    logic                 resetn;
    logic [NRP*5-1:0]     rs_e;
    logic [NRP-1:0]       rs_used_e;
    logic [NRP*XLEN-1:0]  rs_data_e;
    logic [NFWD*5-1:0]    fwd_rd;
    logic [NFWD-1:0]      fwd_wen;
    logic [NFWD-1:0]      fwd_rdy;
    logic [NFWD*XLEN-1:0] fwd_data;
    logic                 ll_issue_vld;
    logic [4:0]           ll_issue_rd;
    logic                 ll_cmpl_vld;
    logic [4:0]           ll_cmpl_rd;
    logic [XLEN-1:0]      ll_cmpl_data;
    logic                 rf_wen;
    logic [4:0]           rf_rd;
    logic [XLEN-1:0]      rf_wdata;
    logic [NRP*XLEN-1:0]  rs_data_byp_e;
    logic                 stall_e;
    logic                 sb_err;

    c7bexu_byp_sb #(.XLEN(XLEN), .NRP(NRP), .NFWD(NFWD), .NHIST(NHIST)) dut (
        .clk(clk), .resetn(resetn),
        .rs_e(rs_e), .rs_used_e(rs_used_e), .rs_data_e(rs_data_e),
        .fwd_rd(fwd_rd), .fwd_wen(fwd_wen), .fwd_rdy(fwd_rdy), .fwd_data(fwd_data),
        .ll_issue_vld(ll_issue_vld), .ll_issue_rd(ll_issue_rd),
        .ll_cmpl_vld(ll_cmpl_vld), .ll_cmpl_rd(ll_cmpl_rd), .ll_cmpl_data(ll_cmpl_data),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
        .rs_data_byp_e(rs_data_byp_e), .stall_e(stall_e), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: set of pending registers, sticky error, recent RF writes (front = newest).
    typedef struct {
        bit        vld;
        bit [4:0]  rd;
        bit [31:0] data;
    } hist_t;

    bit    m_pend [32];
    bit    m_err;
    hist_t m_hist [$];

    function automatic bit [4:0] rs_of(int p);
        return rs_e[p*5 +: 5];
    endfunction

    function automatic bit [31:0] exp_data(int p);
        bit [4:0] rs;
        rs = rs_of(p);
        if (rs == 0) return 32'h0;
        for (int i = 0; i < NFWD; i++)
            if (fwd_wen[i] && fwd_rd[i*5 +: 5] == rs) return fwd_data[i*XLEN +: XLEN];
        if (ll_cmpl_vld && ll_cmpl_rd == rs) return ll_cmpl_data;
`ifdef C7BEXU_BYP_SB_HIST_EN
        foreach (m_hist[k])
            if (m_hist[k].vld && m_hist[k].rd == rs) return m_hist[k].data;
`endif
        return rs_data_e[p*XLEN +: XLEN];
    endfunction

    function automatic bit exp_stall();
        bit s;
        s = 1'b0;
        for (int p = 0; p < NRP; p++) begin
            bit [4:0] rs;
            int hit;
            bit ll_match;
            rs  = rs_of(p);
            hit = -1;
            if (rs_used_e[p] && rs != 0) begin
                for (int i = 0; i < NFWD; i++)
                    if (hit < 0 && fwd_wen[i] && fwd_rd[i*5 +: 5] == rs) hit = i;
                ll_match = ll_cmpl_vld && (ll_cmpl_rd == rs);
                if (hit >= 0 && !fwd_rdy[hit]) s = 1'b1;
                if (m_pend[rs] && hit < 0 && !ll_match) s = 1'b1;
            end
        end
        if (ll_issue_vld && ll_issue_rd != 0 && m_pend[ll_issue_rd] &&
            !(ll_cmpl_vld && ll_cmpl_rd == ll_issue_rd)) s = 1'b1;
        return s;
    endfunction

    task automatic model_reset();
        foreach (m_pend[r]) m_pend[r] = 1'b0;
        m_err = 1'b0;
        m_hist.delete();
    endtask

    task automatic model_update();
        bit    st;
        hist_t h;
        st = exp_stall();
        if (ll_cmpl_vld) begin
            if (m_pend[ll_cmpl_rd]) m_pend[ll_cmpl_rd] = 1'b0;
            else                    m_err = 1'b1;
        end
        if (ll_issue_vld && !st && ll_issue_rd != 0) m_pend[ll_issue_rd] = 1'b1;
        h.vld  = rf_wen && (rf_rd != 0);
        h.rd   = rf_rd;
        h.data = rf_wdata;
        m_hist.push_front(h);
        if (m_hist.size() > NHIST) void'(m_hist.pop_back());
    endtask

    task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic check_model(string tag);
        for (int p = 0; p < NRP; p++)
            cmp($sformatf("%s.data%0d", tag, p), rs_data_byp_e[p*XLEN +: XLEN], exp_data(p));
        cmp({tag, ".stall"}, {31'h0, stall_e}, {31'h0, exp_stall()});
        cmp({tag, ".sb_err"}, {31'h0, sb_err}, {31'h0, m_err});
    endtask

    // Inputs are driven right after a falling edge; settle lets them propagate.
    task automatic settle(string tag);
        #2;
        check_model(tag);
    endtask

    task automatic advance();
        @(posedge clk);
        if (resetn) model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        rs_e = '0; rs_used_e = '1; rs_data_e = '0;
        fwd_rd = '0; fwd_wen = '0; fwd_rdy = '1; fwd_data = '0;
        ll_issue_vld = 1'b0; ll_issue_rd = '0;
        ll_cmpl_vld = 1'b0; ll_cmpl_rd = '0; ll_cmpl_data = '0;
        rf_wen = 1'b0; rf_rd = '0; rf_wdata = '0;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        model_reset();
        settle("reset");
        advance();
        resetn = 1'b1;
    endtask

    task automatic randomize_inputs();
        int cand [$];
        for (int p = 0; p < NRP; p++) begin
            rs_e[p*5 +: 5] = 5'($urandom_range(0, 7));
            rs_data_e[p*XLEN +: XLEN] = $urandom;
        end
        rs_used_e = NRP'($urandom);
        for (int i = 0; i < NFWD; i++) begin
            fwd_rd[i*5 +: 5] = 5'($urandom_range(0, 7));
            fwd_data[i*XLEN +: XLEN] = $urandom;
            fwd_rdy[i] = ($urandom_range(0, 3) != 0);
            fwd_wen[i] = $urandom_range(0, 1) == 1;
        end
        ll_issue_vld = ($urandom_range(0, 3) == 0);
        ll_issue_rd  = 5'($urandom_range(0, 7));
        ll_cmpl_vld  = ($urandom_range(0, 3) == 0);
        ll_cmpl_data = $urandom;
        for (int r = 1; r < 32; r++) if (m_pend[r]) cand.push_back(r);
        if (cand.size() > 0 && $urandom_range(0, 9) != 0)
            ll_cmpl_rd = 5'(cand[$urandom_range(0, cand.size() - 1)]);
        else
            ll_cmpl_rd = 5'($urandom_range(0, 7));
        rf_wen   = $urandom_range(0, 1) == 1;
        rf_rd    = 5'($urandom_range(0, 7));
        rf_wdata = $urandom;
    endtask

    initial begin
        idle();
        resetn = 1'b0;
        model_reset();
        @(negedge clk);
        settle("rst");
        cmp("rst_sb_err_lit", {31'h0, sb_err}, 32'h0);
        cmp("rst_stall_lit", {31'h0, stall_e}, 32'h0);
        advance();
        resetn = 1'b1;

        // Plain RF read, no matches.
        idle();
        rs_e = {5'd2, 5'd1};
        rs_data_e = {32'hBBBBBBBB, 32'hAAAAAAAA};
        settle("rf");
        cmp("rf_p0_lit", rs_data_byp_e[31:0], 32'hAAAAAAAA);
        cmp("rf_p1_lit", rs_data_byp_e[63:32], 32'hBBBBBBBB);
        cmp("rf_stall_lit", {31'h0, stall_e}, 32'h0);
        advance();

        // Youngest forward wins.
        rs_e = {5'd2, 5'd5};
        fwd_rd = {5'd5, 5'd5}; fwd_wen = 2'b11; fwd_rdy = 2'b11;
        fwd_data = {32'h44444444, 32'h33333333};
        settle("fwd");
        cmp("fwd_young_lit", rs_data_byp_e[31:0], 32'h33333333);
        advance();

        // Unready youngest match stalls only a used port.
        fwd_rdy = 2'b10;
        settle("fwd_nrdy");
        cmp("fwd_nrdy_stall_lit", {31'h0, stall_e}, 32'h1);
        rs_used_e = 2'b10;
        settle("fwd_unused");
        cmp("fwd_unused_stall_lit", {31'h0, stall_e}, 32'h0);
        advance();

        // Long-latency RAW: stall until completion, then bypass the returned data.
        idle();
        ll_issue_vld = 1'b1; ll_issue_rd = 5'd7;
        settle("ll_iss");
        advance();
        idle();
        rs_e = {5'd7, 5'd0};
        settle("ll_raw");
        cmp("ll_raw_stall_lit", {31'h0, stall_e}, 32'h1);
        advance();
        ll_cmpl_vld = 1'b1; ll_cmpl_rd = 5'd7; ll_cmpl_data = 32'h12345678;
        settle("ll_cmpl");
        cmp("ll_cmpl_p1_lit", rs_data_byp_e[63:32], 32'h12345678);
        cmp("ll_cmpl_stall_lit", {31'h0, stall_e}, 32'h0);
        advance();
        idle();
        rs_e = {5'd7, 5'd0}; rs_data_e = {32'h77770000, 32'h0};
        settle("ll_clr");
        cmp("ll_cleared_stall_lit", {31'h0, stall_e}, 32'h0);
        cmp("ll_cleared_p1_lit", rs_data_byp_e[63:32], 32'h77770000);
        advance();

        // WAW stall, then a stray completion latches sb_err.
        idle();
        ll_issue_vld = 1'b1; ll_issue_rd = 5'd7;
        settle("waw1");
        advance();
        settle("waw2");
        cmp("waw_stall_lit", {31'h0, stall_e}, 32'h1);
        advance();
        idle();
        ll_cmpl_vld = 1'b1; ll_cmpl_rd = 5'd9;
        settle("stray");
        advance();
        idle();
        settle("err1");
        cmp("sb_err_set_lit", {31'h0, sb_err}, 32'h1);
        advance();
        advance();
        cmp("sb_err_sticky_lit", {31'h0, sb_err}, 32'h1);
        do_reset();
        cmp("sb_err_after_rst_lit", {31'h0, sb_err}, 32'h0);

        // Tracking dropped by reset: x7 was pending before; its completion is now stray.
        idle();
        ll_cmpl_vld = 1'b1; ll_cmpl_rd = 5'd7;
        settle("post_rst_cmpl");
        advance();
        idle();
        settle("post_rst_err");
        cmp("post_rst_err_lit", {31'h0, sb_err}, 32'h1);
        do_reset();

        // History path and x0.
        idle();
        rf_wen = 1'b1; rf_rd = 5'd3; rf_wdata = 32'hCAFEF00D;
        settle("hist_wr");
        advance();
        idle();
        rs_e = {5'd0, 5'd3}; rs_data_e = {32'h0, 32'h11111111};
        settle("hist_rd");
`ifdef C7BEXU_BYP_SB_HIST_EN
        cmp("hist_p0_lit", rs_data_byp_e[31:0], 32'hCAFEF00D);
`else
        cmp("hist_p0_lit", rs_data_byp_e[31:0], 32'h11111111);
`endif
        rs_e = {5'd0, 5'd0}; rs_data_e = {32'h22222222, 32'h11111111};
        fwd_rd = {5'd0, 5'd0}; fwd_wen = 2'b11; fwd_rdy = 2'b00;
        fwd_data = {32'h66666666, 32'h55555555};
        settle("x0");
        cmp("x0_p0_lit", rs_data_byp_e[31:0], 32'h0);
        cmp("x0_stall_lit", {31'h0, stall_e}, 32'h0);
        advance();

        // Randomized traffic against the model, with occasional mid-run resets.
        for (int n = 0; n < 3000; n++) begin
            randomize_inputs();
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                settle("rnd");
                advance();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
